// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and default sizes for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// rtl/mem_arbiter_arb_prio.sv - two-way round-robin pick between port requests
module arb_prio (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic any,
    output logic pick
);

    // pick is the winning port index; prio only matters on a tie
    assign any  = req0 | req1;
    assign pick = (req0 && req1) ? prio : req1;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port burst arbiter in front of a single-ported data memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              last0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              last1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_pos,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    logic             prio;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat0;
    logic             beat1;
    logic             end0;
    logic             end1;
    logic             at_max;
    logic             pick_any;
    logic             pick;

    assign beat0  = (state == SERVE0) && req0;
    assign beat1  = (state == SERVE1) && req1;
    assign at_max = (beat_cnt == CNT_LAST);

    // a burst closes on its last beat, on the MAX_BURST-th beat, or when the owner drops req
    assign end0 = (state == SERVE0) && (!req0 || last0 || at_max);
    assign end1 = (state == SERVE1) && (!req1 || last1 || at_max);

    assign mem_pos  = beat1 ? addr1 : addr0;
    assign mem_data = beat1 ? wdata1 : wdata0;
    assign mem_wr   = (beat0 && we0) || (beat1 && we1);

    arb_prio u_arb_prio (
        .req0 (req0),
        .req1 (req1),
        .prio (prio),
        .any  (pick_any),
        .pick (pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            beat_cnt <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            ack0 <= beat0;
            ack1 <= beat1;
            if (beat0 && !we0) rdata0 <= mem_rdata;
            if (beat1 && !we1) rdata1 <= mem_rdata;

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= pick ? SERVE1 : SERVE0;
                        gnt0     <= !pick;
                        gnt1     <= pick;
                        beat_cnt <= '0;
                    end
                end
                SERVE0: begin
                    if (end0) begin
                        prio     <= 1'b1;
                        beat_cnt <= '0;
                        gnt0     <= 1'b0;
                        gnt1     <= req1;
                        state    <= req1 ? SERVE1 : IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                SERVE1: begin
                    if (end1) begin
                        prio     <= 1'b0;
                        beat_cnt <= '0;
                        gnt1     <= 1'b0;
                        gnt0     <= req0;
                        state    <= req0 ? SERVE0 : IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 12, byte address width seen by the data memory (word index = addr[11:2]).
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Parameter MAX_BURST, 4, max beats per grant before forced hand-over.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 req0 / req1  in  1  port request, held high while beats remain.
REQ-008 we0 / we1  in  1  beat is a write (1) or read (0).
REQ-009 addr0 / addr1  in  ADDR_W  beat byte address.
REQ-010 wdata0 / wdata1  in  DATA_W  write data.
REQ-011 last0 / last1  in  1  current beat is final beat of burst.
REQ-012 gnt0 / gnt1  out  1  port owns memory this cycle.
REQ-013 ack0 / ack1  out  1  one-cycle pulse, beat completed one cycle earlier.
REQ-014 rdata0 / rdata1  out  DATA_W  registered read data, valid when ack high and beat was a read.
REQ-015 mem_pos  out  ADDR_W  address to data memory.
REQ-016 mem_data  out  DATA_W  write data to data memory.
REQ-017 mem_wr  out  1  memory write enable.
REQ-018 mem_rdata  in  DATA_W  combinational read data from memory.

Function
REQ-019 FSM states IDLE, SERVE0, SERVE1; gnt0 = (state==SERVE0), gnt1 = (state==SERVE1), registered.
REQ-020 IDLE: exactly one req high -> SERVE of that port next cycle; both high -> port named by priority pointer prio; neither -> stay IDLE.
REQ-021 A beat executes in any cycle where state==SERVEx and reqx==1; mem_pos/mem_data/mem_wr driven combinationally from port x; mem_wr = wex for that cycle only.
REQ-022 In IDLE, or in SERVEx with reqx==0, mem_wr SHALL be 0; mem_pos/mem_data hold port 0 values (don't-care).
REQ-023 ackx asserted in cycle after each beat; rdatax captures mem_rdata at the beat edge when wex==0, else holds.
REQ-024 Beat counter (clog2(MAX_BURST) bits) cleared on entry to SERVE, incremented per beat.
REQ-025 Burst ends on: beat with lastx==1; beat that is the MAX_BURST-th; or reqx==0 while in SERVEx.
REQ-026 On burst end from SERVEx: prio set to other port; if other req high, next state = SERVE(other) directly (no IDLE cycle); else IDLE.
REQ-027 Forced end at MAX_BURST with reqx still high: port x re-arbitrates; wins again only if other req low.
REQ-028 Address low bits [1:0] passed unmodified; no alignment checking.
REQ-029 Never both gnt0 and gnt1 high; never mem_wr without a granted, requesting port.

Reset
REQ-030 rst_n==0 at a clock edge: state=IDLE, prio=port 0, beat counter=0, gnt0/gnt1=0, ack0/ack1=0, rdata0/rdata1=0.
REQ-031 Reset mid-burst aborts burst; no ack for the aborted beat; mem_wr combinationally 0 while state==IDLE.

Structure
REQ-032 Shared package holds state enum (IDLE/SERVE0/SERVE1) and default ADDR_W/DATA_W/MAX_BURST constants.
REQ-033 One sub-module natural: arb_prio (2-way round-robin pick from req0, req1, prio); rest flat.

Verification
REQ-034 Reset, req0=1 we0=1 addr0=0x004 wdata0=0xDEADBEEF last0=1 -> gnt0 next cycle, mem_wr=1 mem_pos=0x004 one cycle, ack0 following cycle, then IDLE.
REQ-035 Write 0x12345678 to 0x010 via port1, then port0 read 0x010 -> ack0 with rdata0=0x12345678.
REQ-036 req0 and req1 asserted same cycle from reset -> port0 served first, port1 granted the cycle after port0 final beat, no IDLE gap.
REQ-037 req0 held, last0 never asserted, req1 high -> exactly 4 beats for port0, then 4 for port1, alternating.
REQ-038 rst_n low during beat 2 of a port0 write burst -> next cycle gnt0=0, ack0=0, mem_wr=0; rdata0=0.
REQ-039 Random req/we/last on both ports 10k cycles -> gnt mutual exclusion, mem_wr only under grant, memory model matches scoreboard.
